uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Configurable UART receiver, successor to the fixed 8N1 receiver. It adds run-time-independent build options for data width, parity and stop bits, plus 16x oversampling with 3-sample majority vote. It reports parity, framing, overrun and break conditions and delivers frames over a valid/ready output. It sits between the pad-side rx line and any byte consumer, such as a FIFO or command parser.

Parameters:
FREQ, 50_000_000, clk frequency in Hz
RATE, 115_200, baud rate in bit/s
OVERSAMPLE, 16, sample ticks per bit (even, >=8); FREQ >= RATE*OVERSAMPLE is required
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits (1 or 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_rx  in  1  asynchronous serial line, idle high
o_data  out  DATA_BITS  received data, LSB first on line; stable while o_vld=1
o_vld  out  1  frame available
i_rdy  in  1  consumer accepts; transfer occurs when o_vld && i_rdy
o_parity_err  out  1  sideband to o_data; valid while o_vld=1
o_frame_err  out  1  sideband to o_data; any stop bit sampled 0
o_overrun  out  1  one-cycle pulse: completed frame dropped
o_break  out  1  one-cycle pulse: break detected

Behaviour:
- Reset (rst=1 at posedge clk) forces all outputs to 0, the FSM to IDLE, the synchroniser to 1, prev_sample to 0, and the tick counter to 0. Any partial frame is discarded.
- Synchroniser: 2 flops on i_rx, reset to 1; rx_s is the second flop.
- Tick generator:
  - DIV = (FREQ + RATE*OVERSAMPLE/2) / (RATE*OVERSAMPLE), rounded.
  - Free-running counter 0..DIV-1; tick asserts for 1 clk when count = DIV-1.
  - DIV=1 means tick every clk.
- Majority: per bit, rx_s is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit (scnt); the bit value is 2-of-3.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT. All transitions occur on tick only.
  - IDLE: prev_sample <= rx_s each tick. Go to START (scnt=0) when prev_sample=1 && rx_s=0. Because prev_sample resets to 0, the line must be seen high for one tick after reset before any start is accepted.
  - START: if the majority is 1 at scnt=OVERSAMPLE/2+1, this is a false start; go to IDLE. Otherwise go to DATA at scnt=OVERSAMPLE-1.
  - DATA: shift the majority value in LSB-first. After DATA_BITS bits, go to PARITY if PARITY!=0, else go to STOP.
  - PARITY:
    - Even mode: perr = XOR(data, pbit) != 0.
    - Odd mode: perr = XOR(data, pbit) != 1.
  - STOP: ferr |= (majority==0) for each stop bit. Completion happens at the majority decision of the last stop bit; the FSM does not wait for bit end, so it can resync early. On completion go to IDLE with prev_sample=1.
- Break: data all 0, parity bit (if any) 0, and every stop bit 0. Then:
  - o_break pulses for 1 clk;
  - no frame is delivered and o_vld is unaffected;
  - the FSM goes to BRK_WAIT, which returns to IDLE on the first tick with rx_s=1.
- Delivery, 1 clk after completion:
  - o_vld=0: load o_data, o_parity_err and o_frame_err, and set o_vld=1.
  - o_vld=1 && i_rdy=1 in the same cycle: the new frame replaces the old one and o_vld stays 1.
  - o_vld=1 && i_rdy=0: the new frame is dropped, o_overrun pulses 1 clk, and the held data and flags are unchanged.
- o_vld clears on o_vld && i_rdy unless a new frame is loaded that same cycle. Frames with errors are still delivered, with their flags set.
- Latency from the rx falling edge to o_vld: start bit + DATA_BITS + parity bit + (STOP_BITS-1/2) bit times, plus 3 clk for the synchroniser and register, plus up to 1 tick of jitter.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants;
  - FSM state encodings;
  - a constant function computing DIV from FREQ, RATE and OVERSAMPLE.
- Sub-module uart_baud_tick (params FREQ, RATE, OVERSAMPLE; ports clk, rst, o_tick) is shared with the future uart_tx_cfg.

Test Plan:
Bench parameters: FREQ=16_000_000, RATE=1_000_000, OVERSAMPLE=16, giving DIV=1 and 16 clk per bit. Scenario 6 runs with PARITY=0. Scenarios are ordered so each starts from idle line high.

1. 8N1, i_rdy=1, send 0x6A -> o_vld high exactly 1 clk, o_data=0x6A, o_parity_err=0, o_frame_err=0, o_overrun=0.
2. 8E1, send 0x6A with parity bit 1 (correct is 0) -> o_data=0x6A, o_parity_err=1. Resend with parity 0 -> o_parity_err=0.
3. 8N2, send 0x55 with second stop bit 0 -> o_data=0x55, o_frame_err=1. Glitch: rx low 4 clk then high -> no o_vld, FSM back in IDLE.
4. i_rdy=0, send 0x11 then 0x22 -> o_data holds 0x11, o_overrun single pulse at 0x22 completion. Raise i_rdy -> o_vld drops the next clk. Send 0x33 -> received normally.
5. Hold rx low 20 bit times -> o_break one pulse, no o_vld. Release high, send 0xA5 -> o_data=0xA5, no flags.
6. Assert rst mid-data-bit of 0x3C, with the line still low -> no o_vld, outputs 0. Following frame 0xC3 -> received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and baud divider helper for the UART blocks
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    // Rounded clk-per-sample-tick divider.
    function automatic int calc_div(input longint freq, input longint rate, input longint os);
        return int'((freq + (rate * os) / 2) / (rate * os));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator shared by UART rx and tx
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int FREQ       = 50_000_000,
    parameter int RATE       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int DIV = calc_div(FREQ, RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with 3-sample majority vote,
// parity/framing/overrun/break reporting and a valid/ready frame output
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int FREQ       = 50_000_000,
    parameter int RATE       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_break
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD_P     = (PARITY == PARITY_ODD);

    logic tick;

    uart_baud_tick #(.FREQ(FREQ), .RATE(RATE), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           smp_q, smp_d;
    logic                 prev_q, prev_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 ones_q, ones_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 vld_q, vld_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;

    logic rx_s, maj, at_hi, at_end, ones_now, stop_bad_now;

    assign rx_s         = sync_q[1];
    // Valid only at S_HI: smp_q holds the S_LO and S_MID samples, rx_s is the third.
    assign maj          = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
    assign at_hi        = (scnt_q == S_HI);
    assign at_end       = (scnt_q == S_END);
    assign ones_now     = ones_q | maj;
    assign stop_bad_now = stop_bad_q | ~maj;

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], i_rx};
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        smp_d      = smp_q;
        prev_d     = prev_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        ones_d     = ones_q;
        dout_d     = dout_q;
        vld_d      = vld_q & ~i_rdy;
        pe_d       = pe_q;
        fe_d       = fe_q;
        ovr_d      = 1'b0;
        brk_d      = 1'b0;

        if (tick) begin
            scnt_d = at_end ? '0 : scnt_q + 1'b1;
            if (scnt_q == S_LO || scnt_q == S_MID) smp_d = {smp_q[0], rx_s};

            case (state_q)
                ST_IDLE: begin
                    prev_d = rx_s;
                    scnt_d = '0;
                    if (prev_q && !rx_s) begin
                        state_d    = ST_START;
                        bcnt_d     = '0;
                        ones_d     = 1'b0;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                    end
                end
                ST_START: begin
                    if (at_hi && maj) state_d = ST_IDLE;
                    else if (at_end)  state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (at_hi) begin
                        shift_d = {maj, shift_q[DATA_BITS-1:1]};
                        ones_d  = ones_now;
                    end
                    if (at_end) begin
                        if (bcnt_q == LAST_DATA) begin
                            bcnt_d  = '0;
                            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_hi) begin
                        par_bad_d = ((^shift_q) ^ maj) != ODD_P;
                        ones_d    = ones_now;
                    end
                    if (at_end) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (at_hi) begin
                        stop_bad_d = stop_bad_now;
                        ones_d     = ones_now;
                        // Last stop bit decides at its centre so the next start edge is never missed.
                        if (bcnt_q == LAST_STOP) begin
                            if (!ones_now) begin
                                brk_d   = 1'b1;
                                state_d = ST_BRK_WAIT;
                            end else begin
                                state_d = ST_IDLE;
                                prev_d  = 1'b1;
                                if (vld_q && !i_rdy) begin
                                    ovr_d = 1'b1;
                                end else begin
                                    dout_d = shift_q;
                                    pe_d   = par_bad_q;
                                    fe_d   = stop_bad_now;
                                    vld_d  = 1'b1;
                                end
                            end
                        end
                    end else if (at_end) begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                ST_BRK_WAIT: begin
                    scnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        prev_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b11;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            smp_q      <= '0;
            prev_q     <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            ones_q     <= 1'b0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            scnt_q     <= scnt_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            smp_q      <= smp_d;
            prev_q     <= prev_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            ones_q     <= ones_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign o_data       = dout_q;
    assign o_vld        = vld_q;
    assign o_parity_err = pe_q;
    assign o_frame_err  = fe_q;
    assign o_overrun    = ovr_q;
    assign o_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench: 8N1, 8E1 and 8N2 receivers at 16 clk per bit
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx  = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [7:0] dout [3];
    logic [2:0] vld, pe, fe, ovr, brk;

    always #5 clk = ~clk;

    uart_rx_cfg #(.FREQ(16_000_000), .RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .i_rx(rx[0]), .o_data(dout[0]), .o_vld(vld[0]), .i_rdy(rdy[0]),
        .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_overrun(ovr[0]), .o_break(brk[0]));

    uart_rx_cfg #(.FREQ(16_000_000), .RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .i_rx(rx[1]), .o_data(dout[1]), .o_vld(vld[1]), .i_rdy(rdy[1]),
        .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_overrun(ovr[1]), .o_break(brk[1]));

    uart_rx_cfg #(.FREQ(16_000_000), .RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .i_rx(rx[2]), .o_data(dout[2]), .o_vld(vld[2]), .i_rdy(rdy[2]),
        .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_overrun(ovr[2]), .o_break(brk[2]));

    typedef struct {
        logic [7:0] data;
        bit         perr;
        bit         ferr;
        bit         brk;
    } exp_t;

    typedef struct {
        int         idx;
        logic [7:0] d;
        logic       pbit;
        logic [1:0] stops;
        logic [7:0] x_data;
        bit         x_perr;
        bit         x_ferr;
        bit         x_brk;
    } vec_t;

    int nchk = 0;
    int nerr = 0;

    int         vld_cyc [3] = '{0, 0, 0};
    int         xfer    [3] = '{0, 0, 0};
    int         ovr_cnt [3] = '{0, 0, 0};
    int         brk_cnt [3] = '{0, 0, 0};
    logic [7:0] last_d  [3];
    bit         last_pe [3];
    bit         last_fe [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] === 1'b1) vld_cyc[i]++;
            if (vld[i] === 1'b1 && rdy[i] === 1'b1) begin
                xfer[i]++;
                last_d[i]  = dout[i];
                last_pe[i] = pe[i];
                last_fe[i] = fe[i];
            end
            if (ovr[i] === 1'b1) ovr_cnt[i]++;
            if (brk[i] === 1'b1) brk_cnt[i]++;
        end
    end

    function automatic int pm_of(input int idx);
        return (idx == 1) ? 1 : 0;
    endfunction

    function automatic int ns_of(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    // Reference: what a line frame means, from data/parity/stop values alone.
    function automatic exp_t model(input logic [7:0] d, input int pmode, input logic pbit,
                                   input logic [1:0] stops, input int nstop);
        exp_t e;
        int   ones;
        bit   any_low, all_low;
        any_low = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        all_low = (stops[0] == 1'b0) && (nstop == 1 || stops[1] == 1'b0);
        ones    = $countones(d) + ((pmode != 0) ? int'(pbit) : 0);
        e.data  = d;
        e.perr  = (pmode != 0) && ((ones % 2) != ((pmode == 2) ? 1 : 0));
        e.ferr  = any_low;
        e.brk   = (d == 8'h00) && (pmode == 0 || pbit == 1'b0) && all_low;
        return e;
    endfunction

    task automatic chk(input string tag, input string what, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s.%s: actual=%0h required=%0h", tag, what, act, exp);
        end
    endtask

    task automatic put_bit(input int idx, input logic b);
        rx[idx] = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
        put_bit(idx, 1'b0);
        for (int b = 0; b < 8; b++) put_bit(idx, d[b]);
        if (pm_of(idx) != 0) put_bit(idx, pbit);
        for (int s = 0; s < ns_of(idx); s++) put_bit(idx, stops[s]);
        for (int g = 0; g < 3; g++) put_bit(idx, 1'b1);
    endtask

    task automatic run_frame(input int idx, input logic [7:0] d, input logic pbit,
                             input logic [1:0] stops, input exp_t e, input string tag);
        int vc0, xf0, ov0, bk0;
        vc0 = vld_cyc[idx]; xf0 = xfer[idx]; ov0 = ovr_cnt[idx]; bk0 = brk_cnt[idx];
        send_frame(idx, d, pbit, stops);
        #1;
        chk(tag, "overrun", ovr_cnt[idx] - ov0, 0);
        if (e.brk) begin
            chk(tag, "break", brk_cnt[idx] - bk0, 1);
            chk(tag, "xfer", xfer[idx] - xf0, 0);
            chk(tag, "vld_cycles", vld_cyc[idx] - vc0, 0);
        end else begin
            chk(tag, "break", brk_cnt[idx] - bk0, 0);
            chk(tag, "xfer", xfer[idx] - xf0, 1);
            chk(tag, "vld_cycles", vld_cyc[idx] - vc0, 1);
            chk(tag, "data", int'(last_d[idx]), int'(e.data));
            chk(tag, "perr", int'(last_pe[idx]), int'(e.perr));
            chk(tag, "ferr", int'(last_fe[idx]), int'(e.ferr));
        end
    endtask

    task automatic chk_outputs_zero(input int idx, input string tag);
        chk(tag, "o_vld", int'(vld[idx]), 0);
        chk(tag, "o_data", int'(dout[idx]), 0);
        chk(tag, "o_parity_err", int'(pe[idx]), 0);
        chk(tag, "o_frame_err", int'(fe[idx]), 0);
        chk(tag, "o_overrun", int'(ovr[idx]), 0);
        chk(tag, "o_break", int'(brk[idx]), 0);
    endtask

    vec_t tbl [9];

    initial begin
        exp_t e;
        int   vc0, xf0, ov0, bk0;

        tbl[0] = '{0, 8'h6A, 1'b0, 2'b11, 8'h6A, 0, 0, 0};
        tbl[1] = '{1, 8'h6A, 1'b1, 2'b11, 8'h6A, 1, 0, 0};
        tbl[2] = '{1, 8'h6A, 1'b0, 2'b11, 8'h6A, 0, 0, 0};
        tbl[3] = '{2, 8'h55, 1'b0, 2'b01, 8'h55, 0, 1, 0};
        tbl[4] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 0, 0, 0};
        tbl[5] = '{0, 8'h00, 1'b0, 2'b00, 8'h00, 0, 0, 1};
        tbl[6] = '{1, 8'h00, 1'b1, 2'b00, 8'h00, 1, 1, 0};
        tbl[7] = '{2, 8'hFF, 1'b0, 2'b10, 8'hFF, 0, 1, 0};
        tbl[8] = '{1, 8'h81, 1'b0, 2'b11, 8'h81, 0, 0, 0};

        repeat (4) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_outputs_zero(i, $sformatf("reset%0d", i));
        rst = 1'b0;
        repeat (32) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            e = '{tbl[i].x_data, tbl[i].x_perr, tbl[i].x_ferr, tbl[i].x_brk};
            run_frame(tbl[i].idx, tbl[i].d, tbl[i].pbit, tbl[i].stops, e, $sformatf("vec%0d", i));
        end

        vc0 = vld_cyc[2];
        rx[2] = 1'b0;
        repeat (4) @(negedge clk);
        rx[2] = 1'b1;
        repeat (48) @(negedge clk);
        #1;
        chk("glitch", "vld_cycles", vld_cyc[2] - vc0, 0);
        run_frame(2, 8'h3E, 1'b0, 2'b11, '{8'h3E, 0, 0, 0}, "post_glitch");

        rdy[0] = 1'b0;
        ov0 = ovr_cnt[0];
        send_frame(0, 8'h11, 1'b0, 2'b11);
        #1;
        chk("hold", "o_vld", int'(vld[0]), 1);
        chk("hold", "o_data", int'(dout[0]), 'h11);
        send_frame(0, 8'h22, 1'b0, 2'b11);
        #1;
        chk("overrun", "o_vld", int'(vld[0]), 1);
        chk("overrun", "o_data", int'(dout[0]), 'h11);
        chk("overrun", "pulses", ovr_cnt[0] - ov0, 1);
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("drain", "o_vld", int'(vld[0]), 0);
        chk("drain", "data", int'(last_d[0]), 'h11);
        run_frame(0, 8'h33, 1'b0, 2'b11, '{8'h33, 0, 0, 0}, "after_overrun");

        vc0 = vld_cyc[0]; xf0 = xfer[0]; bk0 = brk_cnt[0];
        rx[0] = 1'b0;
        repeat (320) @(negedge clk);
        rx[0] = 1'b1;
        repeat (48) @(negedge clk);
        #1;
        chk("long_break", "pulses", brk_cnt[0] - bk0, 1);
        chk("long_break", "vld_cycles", vld_cyc[0] - vc0, 0);
        chk("long_break", "xfer", xfer[0] - xf0, 0);
        run_frame(0, 8'hA5, 1'b0, 2'b11, '{8'hA5, 0, 0, 0}, "after_break");

        vc0 = vld_cyc[0];
        put_bit(0, 1'b0);
        put_bit(0, 1'b0);
        rx[0] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_outputs_zero(0, "mid_reset");
        rst   = 1'b0;
        rx[0] = 1'b1;
        repeat (48) @(negedge clk);
        #1;
        chk("mid_reset", "vld_cycles", vld_cyc[0] - vc0, 0);
        run_frame(0, 8'hC3, 1'b0, 2'b11, '{8'hC3, 0, 0, 0}, "after_reset");

        for (int n = 0; n < 14; n++) begin
            int         idx;
            logic [7:0] d;
            logic       pbit;
            logic [1:0] stops;
            idx   = int'($urandom_range(0, 2));
            d     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            pbit  = 1'($urandom);
            stops = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            e = model(d, pm_of(idx), pbit, stops, ns_of(idx));
            run_frame(idx, d, pbit, stops, e, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
